lcd_scanout: RTL and testbench

//   Read side of the LCD framebuffer. On a frame request, walks the 128x240 panel
//   in raster order and reads the 32x60 framebuffer at 1/4 resolution per axis.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_scanout_if.sv | 22 ++
 rtl/lcd_palette.sv | 11 +
 rtl/lcd_scanout.sv | 118 +++++++++++
 tb/tb_lcd_scanout.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD scan-out path: geometry, widths, palette, FSM states.
package lcd_pkg;

  localparam int unsigned LCD_H_PIX      = 128;
  localparam int unsigned LCD_V_PIX      = 240;
  localparam int unsigned LCD_SCALE_LOG2 = 2;
  localparam int unsigned FB_W           = 32;
  localparam int unsigned FB_H           = 60;

  localparam int unsigned FRAME_PIX = LCD_H_PIX * LCD_V_PIX;
  localparam int unsigned ROW_W     = $clog2(LCD_V_PIX + 1);
  localparam int unsigned COL_W     = $clog2(LCD_H_PIX);
  localparam int unsigned CNT_W     = $clog2(FRAME_PIX);
  localparam int unsigned FB_AW     = 6;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PIX_W     = 16;

  // RGB565 palette; entries 8..15 are a grey ramp (r = b = v, g = 2v).
  localparam logic [PIX_W-1:0] PALETTE [16] = '{
    16'h0000, 16'hFFFF, 16'hF800, 16'h07E0,
    16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
    16'h1082, 16'h2104, 16'h4208, 16'h630C,
    16'h8410, 16'hA514, 16'hC618, 16'hE71C
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/lcd_scanout_if.sv
// Framebuffer read port plus pixel stream towards the LCD SPI sender.
interface lcd_scanout_if;

  logic [lcd_pkg::FB_AW-1:0] fb_x;
  logic [lcd_pkg::FB_AW-1:0] fb_y;
  logic [lcd_pkg::IDX_W-1:0] fb_data;
  logic [lcd_pkg::PIX_W-1:0] pix_data;
  logic                      pix_valid;
  logic                      pix_last;
  logic                      pix_ready;

  modport master (
    output fb_x, fb_y, pix_data, pix_valid, pix_last,
    input  fb_data, pix_ready
  );

  modport slave (
    input  fb_x, fb_y, pix_data, pix_valid, pix_last,
    output fb_data, pix_ready
  );

endinterface

// File: rtl/lcd_palette.sv
// Combinational colour-index to RGB565 lookup.
module lcd_palette
  import lcd_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [PIX_W-1:0] rgb_c
);

  assign rgb_c = PALETTE[idx];

endmodule

// File: rtl/lcd_scanout.sv
// Raster scan of the panel, upscaling the framebuffer and streaming RGB565 pixels.
module lcd_scanout
  import lcd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_frame,
  output logic          busy,
  output logic          frame_done,
  lcd_scanout_if.master bus
);

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] loaded_q, loaded_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             load;
  logic             accept;
  logic [PIX_W-1:0] pal_rgb;

  lcd_palette u_palette (
    .idx   (bus.fb_data),
    .rgb_c (pal_rgb)
  );

  // Framebuffer address follows the next-pixel counters at 1/4 resolution.
  assign bus.fb_x = FB_AW'(row_q >> LCD_SCALE_LOG2);
  assign bus.fb_y = FB_AW'(col_q >> LCD_SCALE_LOG2);

  assign bus.pix_data  = data_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_last  = last_q;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign accept     = valid_q && bus.pix_ready;

  // State, counters and pixel output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      loaded_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      loaded_q <= loaded_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  // Next-state logic; a load captures the palette output and advances the raster.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    loaded_d = loaded_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          state_d  = ST_FETCH;
          row_d    = '0;
          col_d    = '0;
          loaded_d = '0;
        end
      end
      ST_FETCH: begin
        load    = 1'b1;
        valid_d = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      data_d   = pal_rgb;
      last_d   = (loaded_q == CNT_W'(FRAME_PIX - 1));
      loaded_d = loaded_q + CNT_W'(1);
      if (col_q == COL_W'(LCD_H_PIX - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Self-checking bench for lcd_scanout: vector table plus randomized frame runs.
module tb_lcd_scanout;

  localparam int H = 128;
  localparam int V = 240;
  localparam int N = H * V;
  localparam int FRAME_BUDGET = 60000;

  logic clk = 1'b0;
  logic rst;
  logic start_frame;
  logic busy;
  logic frame_done;

  lcd_scanout_if bus ();

  logic [3:0]  fb_mem [60][32];
  logic [15:0] pal [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        done;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [12];

  lcd_scanout dut (
    .clk         (clk),
    .rst         (rst),
    .start_frame (start_frame),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer model: combinational read of (fb_x, fb_y).
  always_comb begin
    bus.fb_data = 4'h0;
    if (int'(bus.fb_x) < 60 && int'(bus.fb_y) < 32)
      bus.fb_data = fb_mem[int'(bus.fb_x)][int'(bus.fb_y)];
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Panel pixel k shows framebuffer entry (row/4, col/4) through the palette.
  function automatic logic [15:0] exp_pix(input int k);
    int r;
    int c;
    r = k / H;
    c = k % H;
    return pal[fb_mem[r / 4][c / 4]];
  endfunction

  task automatic run_frame(input int stall_pct, input int rst_at, input int mid_start_at);
    int k;
    int nload;
    int cyc;
    bit hold;
    bit done_due;
    bit finished;
    bit pulsed;
    logic [15:0] h_data;
    logic        h_last;
    logic [5:0]  h_x;
    logic [5:0]  h_y;
    k = 0; nload = 0; cyc = 0;
    hold = 0; done_due = 0; finished = 0; pulsed = 0;
    h_data = '0; h_last = 0; h_x = '0; h_y = '0;
    @(negedge clk);
    start_frame   = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    while (!finished) begin
      if (cyc == 0) begin
        chk("fetch busy", cyc, 32'(busy), 32'd1);
        chk("fetch valid low", cyc, 32'(bus.pix_valid), 32'd0);
      end
      if (cyc == 1) chk("first valid", cyc, 32'(bus.pix_valid), 32'd1);
      if (hold) begin
        chk("hold valid", k, 32'(bus.pix_valid), 32'd1);
        chk("hold data", k, 32'(bus.pix_data), 32'(h_data));
        chk("hold last", k, 32'(bus.pix_last), 32'(h_last));
        chk("hold fb_x", k, 32'(bus.fb_x), 32'(h_x));
        chk("hold fb_y", k, 32'(bus.fb_y), 32'(h_y));
      end
      if (done_due) begin
        chk("frame_done pulse", k, 32'(frame_done), 32'd1);
        chk("valid after last", k, 32'(bus.pix_valid), 32'd0);
        chk("busy in done", k, 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy after done", k, 32'(busy), 32'd0);
        chk("frame_done single", k, 32'(frame_done), 32'd0);
        finished = 1;
      end else begin
        if (frame_done) chk("spurious frame_done", k, 32'(frame_done), 32'd0);
        start_frame = 1'b0;
        if (k == mid_start_at && !pulsed) begin
          start_frame = 1'b1;
          pulsed = 1;
        end
        bus.pix_ready = ($urandom_range(99) >= stall_pct);
        if (k == rst_at && bus.pix_valid) begin
          rst = 1'b0;
          start_frame = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          chk("rst valid", k, 32'(bus.pix_valid), 32'd0);
          chk("rst busy", k, 32'(busy), 32'd0);
          chk("rst fb_x", k, 32'(bus.fb_x), 32'd0);
          chk("rst fb_y", k, 32'(bus.fb_y), 32'd0);
          for (int i = 0; i < 5; i++) begin
            chk("rst no frame_done", i, 32'(frame_done), 32'd0);
            @(negedge clk);
          end
          finished = 1;
        end else begin
          if ((busy && !bus.pix_valid && !frame_done) ||
              (bus.pix_valid && bus.pix_ready && !bus.pix_last)) begin
            chk("load fb_x", nload, 32'(bus.fb_x), 32'((nload / H) / 4));
            chk("load fb_y", nload, 32'(bus.fb_y), 32'((nload % H) / 4));
            chk("fb_x range", nload, 32'(bus.fb_x <= 6'd59), 32'd1);
            nload++;
          end
          if (bus.pix_valid && bus.pix_ready) begin
            chk("pix data", k, 32'(bus.pix_data), 32'(exp_pix(k)));
            chk("pix last", k, 32'(bus.pix_last), 32'(k == N - 1));
            if (k == N - 1) done_due = 1;
            k++;
          end
          hold   = bus.pix_valid && !bus.pix_ready;
          h_data = bus.pix_data;
          h_last = bus.pix_last;
          h_x    = bus.fb_x;
          h_y    = bus.fb_y;
          @(negedge clk);
          cyc++;
          if (cyc >= FRAME_BUDGET) begin
            checks++;
            errors++;
            $display("FAIL frame timeout: %0d pixels accepted after %0d cycles, required %0d", k, cyc, N);
            finished = 1;
          end
        end
      end
    end
    start_frame   = 1'b0;
    bus.pix_ready = 1'b1;
  endtask

  // Hang guard: the frame tasks bound their own waits, this only catches a stuck bench.
  initial begin
    #(10 * 150000);
    $display("FAIL global watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start_frame = 1'b0;
    bus.pix_ready = 1'b1;
    pal = '{16'h0000, 16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
            16'h1082, 16'h2104, 16'h4208, 16'h630C, 16'h8410, 16'hA514, 16'hC618, 16'hE71C};
    for (int x = 0; x < 60; x++)
      for (int y = 0; y < 32; y++)
        fb_mem[x][y] = 4'h0;
    fb_mem[10][10] = 4'h4;
    fb_mem[0][0]   = 4'h5;

    //            rst   start ready busy  valid done  x     y     data
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 16'hFFE0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 16'hFFE0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 16'hFFE0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd1, 16'hFFE0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd1, 16'hFFE0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd1, 16'hFFE0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd1, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0000};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      start_frame = vecs[i].start;
      bus.pix_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk("vec busy", i, 32'(busy), 32'(vecs[i].busy));
      chk("vec valid", i, 32'(bus.pix_valid), 32'(vecs[i].valid));
      chk("vec frame_done", i, 32'(frame_done), 32'(vecs[i].done));
      chk("vec fb_x", i, 32'(bus.fb_x), 32'(vecs[i].x));
      chk("vec fb_y", i, 32'(bus.fb_y), 32'(vecs[i].y));
      if (vecs[i].valid) chk("vec data", i, 32'(bus.pix_data), 32'(vecs[i].data));
    end

    @(negedge clk);
    rst = 1'b1;
    start_frame = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Scaling pattern at full throughput, with an ignored start mid-stream.
    run_frame(0, -1, 3000);

    // Random framebuffer contents under 30% backpressure.
    for (int x = 0; x < 60; x++)
      for (int y = 0; y < 32; y++)
        fb_mem[x][y] = 4'($urandom_range(15));
    run_frame(30, -1, -1);

    // Reset mid-frame, then a fresh frame must restart from pixel 0.
    run_frame(0, 5000, -1);
    run_frame(0, 200, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
